// File: rtl/pc_sequencer_if.sv
// Bus bundle for the program-counter sequencer: control inputs, the
// target-table lookup pair and the status outputs.
interface pc_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             ack;
    logic             stall;
    logic             halt;
    logic             jump;
    logic             branch_en;
    logic             taken;
    logic [4:0]       lut_idx;
    logic [4:0]       lut_addr;
    logic [15:0]      target;
    logic [15:0]      pc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] redirects;

    // Driver side: issues instructions/control and serves the target table.
    modport master (
        output start, ack, stall, halt, jump, branch_en, taken, lut_idx, target,
        input  lut_addr, pc, busy, done, redirects
    );

    // Sequencer side.
    modport slave (
        input  start, ack, stall, halt, jump, branch_en, taken, lut_idx, target,
        output lut_addr, pc, busy, done, redirects
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It steps the PC sequentially and handles
// absolute jumps and relative branches through an external target table.
// A taken redirect is decided on one edge, which latches the table index
// and the redirect kind. The PC is updated from the table on the next
// unstalled edge.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] BRANCH = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [15:0]      pc_r;
    logic [15:0]      pc_nxt_s;
    logic [4:0]       lut_addr_r;
    logic [4:0]       lut_addr_nxt_s;
    logic [CNT_W-1:0] redirects_r;
    logic [CNT_W-1:0] redirects_nxt_s;
    logic             kind_jump_r;
    logic             kind_jump_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             redirect_s;

    // A redirect is taken on an unconditional jump or on a branch whose condition holds.
    assign redirect_s = bus.jump | (bus.branch_en & bus.taken);

    // Next-state and datapath decode; every path holds state unless it is explicitly updated.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        lut_addr_nxt_s  = lut_addr_r;
        redirects_nxt_s = redirects_r;
        kind_jump_nxt_s = kind_jump_r;
        case (state_r)
            IDLE: begin
                pc_nxt_s = RESET_PC;
                if (bus.start) begin
                    state_nxt_s     = RUN;
                    redirects_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    state_nxt_s = RUN;
                end else if (bus.halt) begin
                    state_nxt_s = DONE;
                end else if (redirect_s) begin
                    state_nxt_s     = BRANCH;
                    lut_addr_nxt_s  = bus.lut_idx;
                    kind_jump_nxt_s = bus.jump;
                    if (redirects_r != CNT_MAX) begin
                        redirects_nxt_s = redirects_r + CNT_ONE;
                    end else begin
                        redirects_nxt_s = CNT_MAX;
                    end
                end else begin
                    pc_nxt_s = pc_r + 16'd1;
                end
            end
            BRANCH: begin
                if (bus.stall) begin
                    state_nxt_s = BRANCH;
                end else begin
                    state_nxt_s = RUN;
                    if (kind_jump_r) begin
                        pc_nxt_s = bus.target;
                    end else begin
                        // Relative branch; two's-complement add wraps modulo 2^16.
                        pc_nxt_s = pc_r + bus.target;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt_s     = RUN;
                    pc_nxt_s        = RESET_PC;
                    redirects_nxt_s = CNT_ZERO;
                end else if (bus.ack) begin
                    state_nxt_s = IDLE;
                    pc_nxt_s    = RESET_PC;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pc_nxt_s    = RESET_PC;
            end
        endcase
    end

    // Status flags are precomputed from the next state so they can be registered.
    always_comb begin
        busy_nxt_s = (state_nxt_s == RUN) || (state_nxt_s == BRANCH);
        done_nxt_s = (state_nxt_s == DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            lut_addr_r  <= 5'd0;
            redirects_r <= CNT_ZERO;
            kind_jump_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            lut_addr_r  <= lut_addr_nxt_s;
            redirects_r <= redirects_nxt_s;
            kind_jump_r <= kind_jump_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign bus.pc        = pc_r;
    assign bus.lut_addr  = lut_addr_r;
    assign bus.redirects = redirects_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a vector table, a saturation loop,
// a reset taken in the middle of a branch, and a PC wrap check on a second
// instance.
module tb_pc_sequencer;

    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  la;
        logic [7:0]  red;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        logic [6:0] ctl;
        logic [4:0] idx;
        exp_t       e;
    } vec_t;

    // Bit order of ctl: [6]start [5]ack [4]stall [3]halt [2]jump [1]branch_en [0]taken
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] S  = 7'b1000000;
    localparam logic [6:0] A  = 7'b0100000;
    localparam logic [6:0] ST = 7'b0010000;
    localparam logic [6:0] H  = 7'b0001000;
    localparam logic [6:0] J  = 7'b0000100;
    localparam logic [6:0] B  = 7'b0000010;
    localparam logic [6:0] T  = 7'b0000001;

    localparam int NV = 33;

    logic        clk;
    logic        rst;
    logic [15:0] lut [32];
    int          checks;
    int          errors;
    exp_t        sb [$];
    vec_t        vecs [NV];

    pc_sequencer_if #(.CNT_W(8)) if1 ();
    pc_sequencer_if #(.CNT_W(8)) if2 ();

    pc_sequencer #(.RESET_PC(16'h0000), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pc_sequencer #(.RESET_PC(16'hFFFE), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if1.target = lut[if1.lut_addr];
    assign if2.target = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] ctl, input logic [4:0] idx,
                                input logic [15:0] pc, input logic [4:0] la,
                                input logic [7:0] red, input logic b, input logic d);
        vec_t v;
        v.ctl    = ctl;
        v.idx    = idx;
        v.e.pc   = pc;
        v.e.la   = la;
        v.e.red  = red;
        v.e.busy = b;
        v.e.done = d;
        return v;
    endfunction

    function automatic exp_t sample1();
        exp_t s;
        s.pc   = if1.pc;
        s.la   = if1.lut_addr;
        s.red  = if1.redirects;
        s.busy = if1.busy;
        s.done = if1.done;
        return s;
    endfunction

    task automatic check_exp(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual pc=%h la=%0d red=%0d busy=%b done=%b required pc=%h la=%0d red=%0d busy=%b done=%b",
                     name, act.pc, act.la, act.red, act.busy, act.done,
                     req.pc, req.la, req.red, req.busy, req.done);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [4:0] idx);
        if1.start     = ctl[6];
        if1.ack       = ctl[5];
        if1.stall     = ctl[4];
        if1.halt      = ctl[3];
        if1.jump      = ctl[2];
        if1.branch_en = ctl[1];
        if1.taken     = ctl[0];
        if1.lut_idx   = idx;
    endtask

    // Drive one vector, queue its expectation, and score it one edge later.
    task automatic apply(input string name, input vec_t v);
        exp_t req;
        drive(v.ctl, v.idx);
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        req = sb.pop_front();
        check_exp(name, sample1(), req);
    endtask

    initial begin
        exp_t   rz;
        logic [7:0]  exp_red;
        logic [15:0] exp_pc;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) lut[i] = 16'h0100 + 16'(i);
        lut[2] = 16'h0004;
        lut[5] = 16'hFFFE;
        lut[7] = 16'h0007;

        //                ctl     idx    pc        la     red   b     d
        vecs[0]  = mk(N,      5'd0, 16'd0,  5'd0, 8'd0, 1'b0, 1'b0);
        vecs[1]  = mk(S,      5'd0, 16'd0,  5'd0, 8'd0, 1'b1, 1'b0);
        vecs[2]  = mk(N,      5'd0, 16'd1,  5'd0, 8'd0, 1'b1, 1'b0);
        vecs[3]  = mk(N,      5'd0, 16'd2,  5'd0, 8'd0, 1'b1, 1'b0);
        vecs[4]  = mk(N,      5'd0, 16'd3,  5'd0, 8'd0, 1'b1, 1'b0);
        vecs[5]  = mk(J,      5'd2, 16'd3,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[6]  = mk(N,      5'd0, 16'd4,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[7]  = mk(N,      5'd0, 16'd5,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[8]  = mk(N,      5'd0, 16'd6,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[9]  = mk(N,      5'd0, 16'd7,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[10] = mk(N,      5'd0, 16'd8,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[11] = mk(N,      5'd0, 16'd9,  5'd2, 8'd1, 1'b1, 1'b0);
        vecs[12] = mk(N,      5'd0, 16'd10, 5'd2, 8'd1, 1'b1, 1'b0);
        vecs[13] = mk(B|T,    5'd5, 16'd10, 5'd5, 8'd2, 1'b1, 1'b0);
        vecs[14] = mk(H|J,    5'd2, 16'd8,  5'd5, 8'd2, 1'b1, 1'b0);
        vecs[15] = mk(N,      5'd0, 16'd9,  5'd5, 8'd2, 1'b1, 1'b0);
        vecs[16] = mk(N,      5'd0, 16'd10, 5'd5, 8'd2, 1'b1, 1'b0);
        vecs[17] = mk(B,      5'd7, 16'd11, 5'd5, 8'd2, 1'b1, 1'b0);
        vecs[18] = mk(J,      5'd7, 16'd11, 5'd7, 8'd3, 1'b1, 1'b0);
        vecs[19] = mk(ST,     5'd0, 16'd11, 5'd7, 8'd3, 1'b1, 1'b0);
        vecs[20] = mk(ST|S,   5'd1, 16'd11, 5'd7, 8'd3, 1'b1, 1'b0);
        vecs[21] = mk(ST,     5'd0, 16'd11, 5'd7, 8'd3, 1'b1, 1'b0);
        vecs[22] = mk(N,      5'd0, 16'd7,  5'd7, 8'd3, 1'b1, 1'b0);
        vecs[23] = mk(ST|J,   5'd1, 16'd7,  5'd7, 8'd3, 1'b1, 1'b0);
        vecs[24] = mk(H|J,    5'd1, 16'd7,  5'd7, 8'd3, 1'b0, 1'b1);
        vecs[25] = mk(N,      5'd0, 16'd7,  5'd7, 8'd3, 1'b0, 1'b1);
        vecs[26] = mk(A,      5'd0, 16'd0,  5'd7, 8'd3, 1'b0, 1'b0);
        vecs[27] = mk(N,      5'd0, 16'd0,  5'd7, 8'd3, 1'b0, 1'b0);
        vecs[28] = mk(S,      5'd0, 16'd0,  5'd7, 8'd0, 1'b1, 1'b0);
        vecs[29] = mk(N,      5'd0, 16'd1,  5'd7, 8'd0, 1'b1, 1'b0);
        vecs[30] = mk(H,      5'd0, 16'd1,  5'd7, 8'd0, 1'b0, 1'b1);
        vecs[31] = mk(S|A,    5'd0, 16'd0,  5'd7, 8'd0, 1'b1, 1'b0);
        vecs[32] = mk(N,      5'd0, 16'd1,  5'd7, 8'd0, 1'b1, 1'b0);

        rz = '0;
        drive(N, 5'd0);
        if2.start = 1'b0; if2.ack = 1'b0; if2.stall = 1'b0; if2.halt = 1'b0;
        if2.jump = 1'b0; if2.branch_en = 1'b0; if2.taken = 1'b0; if2.lut_idx = 5'd0;

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_exp("reset_state", sample1(), rz);
        check_val("reset_pc_dut2", 32'(if2.pc), 32'h0000FFFE);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Saturation: 260 taken jumps, each followed by its PC-update cycle.
        exp_red = 8'd0;
        exp_pc  = 16'd1;
        for (int i = 0; i < 260; i++) begin
            if (exp_red != 8'hFF) exp_red = exp_red + 8'd1;
            apply($sformatf("sat_dec%0d", i), mk(J, 5'd2, exp_pc, 5'd2, exp_red, 1'b1, 1'b0));
            exp_pc = 16'h0004;
            apply($sformatf("sat_upd%0d", i), mk(N, 5'd0, exp_pc, 5'd2, exp_red, 1'b1, 1'b0));
        end
        check_val("sat_final", 32'(if1.redirects), 32'd255);

        // Asynchronous reset while a branch is pending.
        apply("pre_rst_branch", mk(B|T, 5'd5, 16'd4, 5'd5, 8'd255, 1'b1, 1'b0));
        drive(N, 5'd0);
        rst = 1'b1;
        #1;
        check_exp("async_rst_now", sample1(), rz);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_exp("rst_held", sample1(), rz);
        rst = 1'b0;
        apply("post_rst_idle0", mk(N, 5'd0, 16'd0, 5'd0, 8'd0, 1'b0, 1'b0));
        apply("post_rst_idle1", mk(N, 5'd0, 16'd0, 5'd0, 8'd0, 1'b0, 1'b0));
        apply("post_rst_start", mk(S, 5'd0, 16'd0, 5'd0, 8'd0, 1'b1, 1'b0));
        apply("post_rst_seq",   mk(N, 5'd0, 16'd1, 5'd0, 8'd0, 1'b1, 1'b0));

        // PC wrap on the instance with RESET_PC = FFFE.
        check_val("wrap_idle", 32'(if2.pc), 32'h0000FFFE);
        if2.start = 1'b1;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        check_val("wrap_pc0", 32'(if2.pc), 32'h0000FFFE);
        check_val("wrap_busy", 32'(if2.busy), 32'd1);
        @(posedge clk);
        #1;
        check_val("wrap_pc1", 32'(if2.pc), 32'h0000FFFF);
        @(posedge clk);
        #1;
        check_val("wrap_pc2", 32'(if2.pc), 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the program counter value loaded at reset and on every start.
REQ-002 Parameter CNT_W, default 8, is the width of the redirect counter.
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port Reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 Port Start, input, 1 bit: begin a program run; sampled only in IDLE and DONE.
REQ-006 Port Ack, input, 1 bit: acknowledges Done.
REQ-007 Port Stall, input, 1 bit: freezes the sequencer for the cycle.
REQ-008 Port Halt, input, 1 bit: the current instruction is a halt.
REQ-009 Port Jump, input, 1 bit: the current instruction is an unconditional absolute jump.
REQ-010 Port BranchEn, input, 1 bit: the current instruction is a conditional relative branch.
REQ-011 Port Taken, input, 1 bit: the branch condition is true.
REQ-012 Port LutIdx, input, 5 bits: the target-table index encoded in the instruction.
REQ-013 Port LutAddr, output, 5 bits: registered index driven to the target lookup table.
REQ-014 Port Target, input, 16 bits: the table entry for LutAddr, combinational from LutAddr.
REQ-015 Port PC, output, 16 bits: the current program counter (registered).
REQ-016 Port Busy, output, 1 bit: high in RUN and BRANCH.
REQ-017 Port Done, output, 1 bit: high in DONE.
REQ-018 Port Redirects, output, CNT_W bits: count of taken jumps and branches in the current run.

Function
REQ-019 The state machine SHALL have four states: IDLE, RUN, BRANCH and DONE; all outputs are registered or decoded from state only.
REQ-020 In IDLE:
- PC holds RESET_PC.
- Start=1 -> RUN, PC<=RESET_PC, Redirects<=0.
REQ-021 In RUN with Stall=1, PC, LutAddr, Redirects and state SHALL all hold.
REQ-022 In RUN with Stall=0, priority SHALL be Halt > Jump > (BranchEn & Taken) > sequential.
REQ-023 RUN, Halt=1 -> DONE; PC holds the halt address.
REQ-024 RUN, Jump=1 or (BranchEn=1 and Taken=1):
- LutAddr<=LutIdx, PC holds, Redirects increments, next state BRANCH.
- Redirects SHALL saturate at all-ones, with no wrap.
REQ-025 RUN, otherwise -> PC<=PC+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-026 RUN, BranchEn=1 with Taken=0 SHALL behave as sequential.
REQ-027 BRANCH with Stall=1 SHALL hold all state, and LutAddr stays stable.
REQ-028 BRANCH with Stall=0 SHALL update PC, then return to RUN:
- Jump: PC<=Target (absolute).
- Branch: PC<=PC+Target, Target two's-complement signed, sum modulo 2^16.
REQ-029 The jump/branch kind SHALL be latched in RUN; inputs Halt, Jump, BranchEn, Taken and LutIdx are ignored in BRANCH.
REQ-030 Redirect latency SHALL be two cycles: the decision edge, then the PC-update edge. Sequential latency SHALL be one cycle.
REQ-031 In DONE:
- Done=1 and PC holds.
- Ack=1 -> IDLE, PC<=RESET_PC.
- Start=1 with Ack=0 -> RUN, restarting as in REQ-020.
- Start and Ack both 1 -> RUN (Start wins).
REQ-032 Start asserted in RUN or BRANCH SHALL be ignored.
REQ-033 LutAddr SHALL change only on entry to BRANCH and retain its value otherwise.

Reset
REQ-034 While Reset=1, asynchronously and in any state, the block SHALL force:
- state=IDLE, PC=RESET_PC, LutAddr=0, Redirects=0, Busy=0, Done=0.
REQ-035 Reset asserted mid-BRANCH SHALL abandon the pending PC update.
REQ-036 After Reset deasserts, the first transition SHALL require Start.

Verification
REQ-037 Sequential run: Start pulse, no control inputs for 5 cycles -> PC 0,1,2,3,4,5 and Busy=1.
REQ-038 Jump: at PC=3, Jump=1, LutIdx=2, Target=16'h0004 -> LutAddr=2 next cycle, PC=3 held one cycle, then PC=4, Redirects=1.
REQ-039 Relative branch: at PC=10, BranchEn=1, Taken=1, Target=16'hFFFE -> PC=8. The same case with Taken=0 -> PC=11.
REQ-040 Priority and stall:
- Halt=1 and Jump=1 together at PC=7 -> DONE, PC=7, Done=1, Redirects unchanged.
- Stall=1 for 3 cycles in BRANCH -> PC and LutAddr frozen, update on the first unstalled edge.
REQ-041 Wrap and saturation:
- RESET_PC=16'hFFFE -> PC FFFE, FFFF, 0000.
- 260 taken jumps with CNT_W=8 -> Redirects=255.
REQ-042 Asynchronous reset mid-BRANCH -> outputs reset immediately, without waiting for a clock edge; after release, PC=RESET_PC and no transition occurs until Start.
